mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port synchronous memory between the CPU instruction-fetch port and the data port, replacing the two separate memory interfaces in unified-memory builds.
- Grants one transaction at a time. Data requests take priority, with a starvation guard for fetch.
- Drives cpu_stall so the CPU core holds its PC and register writes until the grant completes.
- Sits between the CPU and the memory macro.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
MEM_LAT, 1, memory read latency in cycles (legal 1..4)
STARVE_MAX, 4, consecutive data grants allowed while fetch waits (legal >=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
if_req  in  1  fetch read request; held until if_ack
if_addr  in  ADDR_W  fetch address
if_ack  out  1  one-cycle pulse; if_rdata valid this cycle
if_rdata  out  DATA_W  fetch data
dm_req  in  1  data request; held until dm_ack
dm_we  in  4  byte write enables; 0 = read
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  write data
dm_ack  out  1  one-cycle completion pulse
dm_rdata  out  DATA_W  load data, valid with dm_ack
mem_en  out  1  memory access strobe (registered)
mem_we  out  4  memory byte enables (registered)
mem_addr  out  ADDR_W  memory address (registered)
mem_wdata  out  DATA_W  memory write data (registered)
mem_rdata  in  DATA_W  memory read data
cpu_stall  out  1  (if_req & ~if_ack) | (dm_req & ~dm_ack), combinational

Behaviour:
- Reset (rst=0, async):
  - State returns to IDLE; owner=NONE; lat_cnt=0; starve_cnt=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0; if_ack=dm_ack=0.
- Reset mid-transaction: aborts the access, and no ack is ever issued for it.
- FSM, two states: IDLE and BUSY.
- IDLE, no request: mem_en=0 and state holds.
- IDLE, request present: choose the winner. On the next edge:
  - Load mem_en=1 and the winner's addr/we/wdata into the mem_* registers (if_req is a read: mem_we=0).
  - Set owner and lat_cnt=1; go to BUSY.
- Arbitration:
  - Only dm_req: data wins. Only if_req: fetch wins.
  - Both requesting, starve_cnt<STARVE_MAX: data wins, starve_cnt+1.
  - Both requesting, starve_cnt==STARVE_MAX: fetch wins.
  - Any fetch grant clears starve_cnt. A data grant with if_req low leaves it unchanged.
- BUSY:
  - mem_en is 1 only in the first BUSY cycle, then cleared. mem_addr/mem_we/mem_wdata hold until the next issue.
  - The memory samples at the edge ending the first BUSY cycle. mem_rdata is valid when lat_cnt==MEM_LAT+... counted as follows: lat_cnt increments each BUSY cycle, and the ack cycle is lat_cnt==MEM_LAT+1.
  - Writes (mem_we!=0) ack at lat_cnt==2 regardless of MEM_LAT.
  - Ack cycle: owner's ack=1 and rdata=mem_rdata (pass-through). Next edge: IDLE, owner=NONE.
- Timing (request seen in cycle 0, MEM_LAT=1):
  - mem_en in cycle 1, ack in cycle 2, IDLE in cycle 3.
  - Next issue: mem_en in cycle 4.
  - Read ack is in cycle 1+MEM_LAT+... i.e. cycle MEM_LAT+1 after issue-decision cycle 0; write ack is in cycle 2.
- if_rdata/dm_rdata outside the ack cycle: don't care, but driven with mem_rdata.
- Request inputs are sampled only in IDLE; changes during BUSY are ignored. A requester dropping req before its ack is a protocol violation: the transaction completes and the ack still pulses.
- Only one outstanding transaction. Never ack both ports in the same cycle.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding IDLE/BUSY;
  - owner encoding NONE/IF/DM;
  - width constants for lat_cnt (3 bits) and starve_cnt.
- One sub-module is natural: mem_arb_prio. It takes both reqs plus starve_cnt and produces the winner and the next starve_cnt, and owns the starvation counter register.

Test Plan:
- Single fetch read, MEM_LAT=1: if_req=1, if_addr=0x100, mem returns 0xDEADBEEF -> mem_en=1 with mem_addr=0x100 in cycle 1; if_ack=1 and if_rdata=0xDEADBEEF in cycle 2; cpu_stall=1 in cycles 0-1 and 0 in cycle 2.
- Byte store: dm_req=1, dm_we=4'b0010, dm_addr=0x204, dm_wdata=0x0000AB00 -> mem_en=1, mem_we=0010, mem_addr=0x204 in cycle 1; dm_ack in cycle 2; no if_ack.
- Both requesting continuously, STARVE_MAX=4 -> grant order DM,DM,DM,DM,IF,DM...; fetch granted on the 5th transaction; starve_cnt returns to 0.
- MEM_LAT=3 load at 0x40 -> mem_en in cycle 1; dm_ack only in cycle 4; dm_rdata equals the memory value; mem_en=0 in cycles 2-4.
- Reset asserted in cycle 2 of a MEM_LAT=3 read -> mem_en=0 and acks=0 immediately (async); after release, IDLE; the held request is reissued from scratch.
- Request change during BUSY: dm_addr switched from 0x10 to 0x20 after issue -> mem_addr stays 0x10 through the ack.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM/owner encodings and counter widths.
// Imported by the interface, the priority picker and the arbiter top.
package mem_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

  localparam int LAT_W    = 3;
  localparam int STARVE_W = 8;
  localparam int WE_W     = 4;

  // Writes retire one cycle after the strobe; reads wait out the macro latency.
  function automatic logic [LAT_W-1:0] ack_lat(input logic is_wr, input int mem_lat);
    return is_wr ? LAT_W'(2) : LAT_W'(mem_lat + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU fetch/data ports plus the single-port memory macro bus, bundled for the arbiter.
// slave = arbiter view; master = CPU core and memory macro view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                          if_req;
  logic [ADDR_W-1:0]             if_addr;
  logic                          if_ack;
  logic [DATA_W-1:0]             if_rdata;

  logic                          dm_req;
  logic [mem_arb_pkg::WE_W-1:0]  dm_we;
  logic [ADDR_W-1:0]             dm_addr;
  logic [DATA_W-1:0]             dm_wdata;
  logic                          dm_ack;
  logic [DATA_W-1:0]             dm_rdata;

  logic                          mem_en;
  logic [mem_arb_pkg::WE_W-1:0]  mem_we;
  logic [ADDR_W-1:0]             mem_addr;
  logic [DATA_W-1:0]             mem_wdata;
  logic [DATA_W-1:0]             mem_rdata;

  logic                          cpu_stall;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, cpu_stall
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, cpu_stall
  );
endinterface

// File: rtl/mem_arb_prio.sv
// Picks fetch or data for the next memory slot; data wins unless fetch has lost STARVE_MAX times.
// Combinational winner; the starvation count only advances on a granted slot.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   if_req_i,
  input  logic   dm_req_i,
  input  logic   grant_i,
  output owner_e winner_o
);

  logic [STARVE_W-1:0] starve_q, starve_d;

  always_comb begin
    winner_o = OWN_NONE;
    starve_d = starve_q;
    if (if_req_i && dm_req_i) begin
      if (starve_q < STARVE_W'(STARVE_MAX)) begin
        winner_o = OWN_DM;
        starve_d = starve_q + STARVE_W'(1);
      end else begin
        winner_o = OWN_IF;
        starve_d = '0;
      end
    end else if (dm_req_i) begin
      winner_o = OWN_DM;
    end else if (if_req_i) begin
      winner_o = OWN_IF;
      starve_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else if (grant_i) begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Time-shares one single-port synchronous memory between CPU fetch and data ports, one access at a time.
// Issue 1 cycle after request; ack MEM_LAT+1 cycles after issue decision (writes: 2); cpu_stall holds the core meanwhile.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic                mem_en_q, mem_en_d;
  logic [WE_W-1:0]     mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  owner_e winner;
  logic   grant;
  logic   ack_hit;

  assign grant   = (state_q == ST_IDLE) && (bus.if_req || bus.dm_req);
  assign ack_hit = (state_q == ST_BUSY) && (lat_q == ack_lat(|mem_we_q, MEM_LAT));

  mem_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk      (clk),
    .rst      (rst),
    .if_req_i (bus.if_req),
    .dm_req_i (bus.dm_req),
    .grant_i  (grant),
    .winner_o (winner)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lat_d       = lat_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d  = ST_BUSY;
          owner_d  = winner;
          lat_d    = LAT_W'(1);
          mem_en_d = 1'b1;
          if (winner == OWN_DM) begin
            mem_we_d    = bus.dm_we;
            mem_addr_d  = bus.dm_addr;
            mem_wdata_d = bus.dm_wdata;
          end else begin
            // Fetch is always a read; leave the stale write data in place.
            mem_we_d   = '0;
            mem_addr_d = bus.if_addr;
          end
        end
      end
      ST_BUSY: begin
        if (ack_hit) begin
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
          lat_d   = '0;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_NONE;
      lat_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lat_q       <= lat_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.if_ack    = ack_hit && (owner_q == OWN_IF);
  assign bus.dm_ack    = ack_hit && (owner_q == OWN_DM);
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.dm_rdata  = bus.mem_rdata;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_stall = (bus.if_req && !bus.if_ack) || (bus.dm_req && !bus.dm_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: two arbiters (MEM_LAT=1 and MEM_LAT=3) each against a small synchronous memory model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter_if ba ();
  mem_arbiter_if bb ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_a (
    .clk (clk), .rst (rst), .bus (ba)
  );
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_b (
    .clk (clk), .rst (rst), .bus (bb)
  );

  // Memory macro models: sample on the strobe edge, data visible MEM_LAT cycles later, for one cycle only.
  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];
  logic [31:0] rd_a;
  logic [31:0] pipe_b [0:2];

  function automatic logic [31:0] init_word(input int i);
    case (i)
      64:      return 32'hDEADBEEF;
      129:     return 32'h11223344;
      16:      return 32'hCAFEF00D;
      4:       return 32'h10101010;
      8:       return 32'h20202020;
      default: return {24'h5A5A5A, 8'(i)};
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= init_word(i);
      rd_a <= 32'hBAD0BAD0;
    end else begin
      rd_a <= 32'hBAD0BAD0;
      if (ba.mem_en) begin
        if (ba.mem_we == 4'h0) rd_a <= mem_a[ba.mem_addr[9:2]];
        else for (int b = 0; b < 4; b++)
          if (ba.mem_we[b]) mem_a[ba.mem_addr[9:2]][b*8 +: 8] <= ba.mem_wdata[b*8 +: 8];
      end
    end
  end
  assign ba.mem_rdata = rd_a;

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) mem_b[i] <= init_word(i);
      for (int s = 0; s < 3; s++) pipe_b[s] <= 32'hBAD0BAD0;
    end else begin
      pipe_b[0] <= 32'hBAD0BAD0;
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
      if (bb.mem_en) begin
        if (bb.mem_we == 4'h0) pipe_b[0] <= mem_b[bb.mem_addr[9:2]];
        else for (int b = 0; b < 4; b++)
          if (bb.mem_we[b]) mem_b[bb.mem_addr[9:2]][b*8 +: 8] <= bb.mem_wdata[b*8 +: 8];
      end
    end
  end
  assign bb.mem_rdata = pipe_b[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  int          n_ack;
  int          budget;
  logic [31:0] exp_ord [0:5];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    ba.if_req = 1'b0; ba.if_addr = '0; ba.dm_req = 1'b0; ba.dm_we = '0; ba.dm_addr = '0; ba.dm_wdata = '0;
    bb.if_req = 1'b0; bb.if_addr = '0; bb.dm_req = 1'b0; bb.dm_we = '0; bb.dm_addr = '0; bb.dm_wdata = '0;
    exp_ord[0] = 2; exp_ord[1] = 2; exp_ord[2] = 2; exp_ord[3] = 2; exp_ord[4] = 1; exp_ord[5] = 2;

    // Reset values
    repeat (3) @(posedge clk);
    mid;
    check("rst_mem_en",    ba.mem_en, 0);
    check("rst_mem_we",    ba.mem_we, 0);
    check("rst_mem_addr",  ba.mem_addr, 0);
    check("rst_mem_wdata", ba.mem_wdata, 0);
    check("rst_if_ack",    ba.if_ack, 0);
    check("rst_dm_ack",    ba.dm_ack, 0);
    check("rst_stall",     ba.cpu_stall, 0);
    check("rst_b_mem_en",  bb.mem_en, 0);
    next_cyc; rst = 1'b1;

    // Fetch read at 0x100, then a back-to-back fetch at 0x10
    next_cyc; ba.if_req = 1'b1; ba.if_addr = 32'h100;
    mid; check("f_c0_stall", ba.cpu_stall, 1); check("f_c0_en", ba.mem_en, 0);
    next_cyc; mid;
    check("f_c1_en", ba.mem_en, 1); check("f_c1_addr", ba.mem_addr, 32'h100);
    check("f_c1_we", ba.mem_we, 0); check("f_c1_stall", ba.cpu_stall, 1); check("f_c1_ack", ba.if_ack, 0);
    next_cyc; mid;
    check("f_c2_ack", ba.if_ack, 1); check("f_c2_rdata", ba.if_rdata, 32'hDEADBEEF);
    check("f_c2_stall", ba.cpu_stall, 0); check("f_c2_dmack", ba.dm_ack, 0); check("f_c2_en", ba.mem_en, 0);
    next_cyc; ba.if_addr = 32'h10;
    mid; check("f_c3_en", ba.mem_en, 0); check("f_c3_ack", ba.if_ack, 0);
    next_cyc; mid; check("f_c4_en", ba.mem_en, 1); check("f_c4_addr", ba.mem_addr, 32'h10);
    next_cyc; mid; check("f_c5_ack", ba.if_ack, 1); check("f_c5_rdata", ba.if_rdata, 32'h10101010);
    next_cyc; ba.if_req = 1'b0;
    mid; check("f_c6_ack", ba.if_ack, 0);

    // Byte store to 0x204, then read it back
    next_cyc; ba.dm_req = 1'b1; ba.dm_we = 4'b0010; ba.dm_addr = 32'h204; ba.dm_wdata = 32'h0000AB00;
    next_cyc; mid;
    check("st_c1_en", ba.mem_en, 1); check("st_c1_we", ba.mem_we, 4'b0010);
    check("st_c1_addr", ba.mem_addr, 32'h204); check("st_c1_wdata", ba.mem_wdata, 32'h0000AB00);
    next_cyc; mid; check("st_c2_ack", ba.dm_ack, 1); check("st_c2_ifack", ba.if_ack, 0);
    next_cyc; ba.dm_req = 1'b0; ba.dm_we = 4'b0000;
    next_cyc; ba.dm_req = 1'b1;
    next_cyc; mid; check("ld_c1_we", ba.mem_we, 0);
    next_cyc; mid; check("ld_c2_ack", ba.dm_ack, 1); check("ld_c2_rdata", ba.dm_rdata, 32'h1122AB44);
    next_cyc; ba.dm_req = 1'b0;

    // Both requesting continuously: DM x4, IF, DM
    next_cyc;
    ba.if_req = 1'b1; ba.if_addr = 32'h100; ba.dm_req = 1'b1; ba.dm_we = 4'b0000; ba.dm_addr = 32'h40;
    n_ack = 0; budget = 0;
    while (n_ack < 6 && budget < 60) begin
      mid;
      check("no_dual_ack", ba.if_ack & ba.dm_ack, 0);
      if (ba.if_ack || ba.dm_ack) begin
        check($sformatf("order%0d", n_ack), ba.dm_ack ? 32'd2 : 32'd1, exp_ord[n_ack]);
        if (n_ack == 3) check("starve_at4", u_a.u_prio.starve_q, 4);
        if (n_ack == 4) check("starve_clr", u_a.u_prio.starve_q, 0);
        n_ack++;
      end
      budget++;
    end
    check("starve_acks", n_ack, 6);
    check("starve_after", u_a.u_prio.starve_q, 1);
    ba.if_req = 1'b0; ba.dm_req = 1'b0;

    // MEM_LAT=3 load at 0x40
    next_cyc; bb.dm_req = 1'b1; bb.dm_we = 4'b0000; bb.dm_addr = 32'h40;
    next_cyc; mid; check("l3_c1_en", bb.mem_en, 1); check("l3_c1_addr", bb.mem_addr, 32'h40); check("l3_c1_ack", bb.dm_ack, 0);
    for (int c = 2; c <= 3; c++) begin
      next_cyc; mid;
      check($sformatf("l3_c%0d_en", c), bb.mem_en, 0);
      check($sformatf("l3_c%0d_ack", c), bb.dm_ack, 0);
    end
    next_cyc; mid;
    check("l3_c4_ack", bb.dm_ack, 1); check("l3_c4_rdata", bb.dm_rdata, 32'hCAFEF00D);
    check("l3_c4_en", bb.mem_en, 0); check("l3_c4_ifack", bb.if_ack, 0);
    next_cyc; bb.dm_req = 1'b0;
    mid; check("l3_c5_ack", bb.dm_ack, 0);

    // MEM_LAT=3 write still acks two cycles after the request
    next_cyc; bb.dm_req = 1'b1; bb.dm_we = 4'hF; bb.dm_addr = 32'h44; bb.dm_wdata = 32'h55;
    next_cyc; mid; check("w3_c1_en", bb.mem_en, 1); check("w3_c1_we", bb.mem_we, 4'hF); check("w3_c1_ack", bb.dm_ack, 0);
    next_cyc; mid; check("w3_c2_ack", bb.dm_ack, 1);
    next_cyc; bb.dm_req = 1'b0; bb.dm_we = 4'h0;
    mid; check("w3_c3_ack", bb.dm_ack, 0);

    // Reset in cycle 2 of a MEM_LAT=3 read; request stays held and is reissued
    next_cyc; bb.dm_req = 1'b1; bb.dm_addr = 32'h40;
    next_cyc; mid; check("rr_c1_en", bb.mem_en, 1);
    next_cyc; rst = 1'b0;
    #1;
    check("rr_async_en", bb.mem_en, 0); check("rr_async_addr", bb.mem_addr, 0);
    check("rr_async_ack", bb.dm_ack, 0); check("rr_starve_a", u_a.u_prio.starve_q, 0);
    for (int c = 3; c <= 4; c++) begin
      next_cyc; mid;
      check($sformatf("rr_c%0d_ack", c), bb.dm_ack, 0);
      check($sformatf("rr_c%0d_en", c), bb.mem_en, 0);
    end
    next_cyc; rst = 1'b1;
    mid; check("rr_c5_en", bb.mem_en, 0); check("rr_c5_stall", bb.cpu_stall, 1);
    next_cyc; mid; check("rr_c6_en", bb.mem_en, 1); check("rr_c6_addr", bb.mem_addr, 32'h40);
    for (int c = 7; c <= 8; c++) begin
      next_cyc; mid;
      check($sformatf("rr_c%0d_ack", c), bb.dm_ack, 0);
    end
    next_cyc; mid; check("rr_c9_ack", bb.dm_ack, 1); check("rr_c9_rdata", bb.dm_rdata, 32'hCAFEF00D);
    next_cyc; bb.dm_req = 1'b0;

    // Address change while BUSY is ignored
    next_cyc; ba.dm_req = 1'b1; ba.dm_we = 4'b0000; ba.dm_addr = 32'h10;
    next_cyc; ba.dm_addr = 32'h20;
    mid; check("ch_c1_en", ba.mem_en, 1); check("ch_c1_addr", ba.mem_addr, 32'h10);
    next_cyc; mid;
    check("ch_c2_ack", ba.dm_ack, 1); check("ch_c2_addr", ba.mem_addr, 32'h10);
    check("ch_c2_rdata", ba.dm_rdata, 32'h10101010);
    next_cyc; ba.dm_req = 1'b0;
    mid; check("ch_c3_addr", ba.mem_addr, 32'h10); check("ch_c3_en", ba.mem_en, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
